// File: rtl/fdiv_share_arbiter.sv
// ============================================================================
//  Module      : fdiv_share_arbiter
//  Description : Round-robin arbiter sharing one single-precision divider
//                among N requesters. One operation in flight at a time:
//                request accept -> divider issue -> divider result ->
//                result delivery to the owning requester.
//  Ports       : clk, rst_n           clock, async active-low reset
//                req_a/req_b/req_stb  per-requester operands and strobe
//                req_ack              per-requester accept (one-hot or 0)
//                res_z/res_stb        shared result bus, per-requester strobe
//                res_ack              per-requester result accept
//                div_a/div_b/div_stb  divider operand port
//                div_in_ack           divider operand accept
//                div_z/div_z_stb      divider result port
//                div_z_ack            divider result accept
//                busy, grant          status: not idle, current/last owner
//                ops_done             completed operation count (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fdiv_share_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*32-1:0] req_a,
    input  logic [N*32-1:0] req_b,
    input  logic [N-1:0]    req_stb,
    output logic [N-1:0]    req_ack,
    output logic [31:0]     res_z,
    output logic [N-1:0]    res_stb,
    input  logic [N-1:0]    res_ack,
    output logic [31:0]     div_a,
    output logic [31:0]     div_b,
    output logic            div_stb,
    input  logic            div_in_ack,
    input  logic [31:0]     div_z,
    input  logic            div_z_stb,
    output logic            div_z_ack,
    output logic            busy,
    output logic [IW-1:0]   grant,
    output logic [15:0]     ops_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACCEPT  = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_DELIVER = 3'd4;

    logic [2:0]    state;
    logic [IW-1:0] last;
    logic [IW-1:0] pick;
    logic [31:0]   sel_a;
    logic [31:0]   sel_b;
    logic          sel_stb;
    logic          sel_res_ack;
    int            idx;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] g);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (g == IW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Round-robin pick: scan from last+1 upward with wrap. The loop runs
    // from the lowest-priority offset (last itself) towards last+1 so the
    // final overwrite is the highest-priority pending requester.
    always_comb begin
        pick = last;
        idx  = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req_stb[idx]) pick = IW'(idx);
        end
    end

    // Per-owner views of the requester-side buses.
    always_comb begin
        sel_a       = '0;
        sel_b       = '0;
        sel_stb     = 1'b0;
        sel_res_ack = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant == IW'(i)) begin
                sel_a       = req_a[32*i +: 32];
                sel_b       = req_b[32*i +: 32];
                sel_stb     = req_stb[i];
                sel_res_ack = res_ack[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_ack   <= '0;
            res_stb   <= '0;
            res_z     <= '0;
            div_a     <= '0;
            div_b     <= '0;
            div_stb   <= 1'b0;
            div_z_ack <= 1'b0;
            busy      <= 1'b0;
            ops_done  <= '0;
            last      <= IW'(N-1);
            grant     <= IW'(N-1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_stb) begin
                        req_ack <= onehot(pick);
                        grant   <= pick;
                        busy    <= 1'b1;
                        state   <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    // req_ack of the owner is always high here, so its
                    // strobe alone marks the transfer edge.
                    req_ack <= '0;
                    if (sel_stb) begin
                        div_a   <= sel_a;
                        div_b   <= sel_b;
                        div_stb <= 1'b1;
                        state   <= S_ISSUE;
                    end else begin
                        // Requester withdrew: drop it without touching last.
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (div_in_ack) begin
                        div_stb   <= 1'b0;
                        div_z_ack <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (div_z_stb) begin
                        res_z     <= div_z;
                        div_z_ack <= 1'b0;
                        res_stb   <= onehot(grant);
                        state     <= S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    if (sel_res_ack) begin
                        res_stb  <= '0;
                        last     <= grant;
                        ops_done <= ops_done + 16'd1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    req_ack   <= '0;
                    res_stb   <= '0;
                    div_stb   <= 1'b0;
                    div_z_ack <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
